// File: rtl/spi_slave_ctrl_if.sv
// SPI slave controller bus bundle.
//
// Groups the SPI pins and the parallel TX/RX/status signals of
// spi_slave_ctrl so they travel as one port. Clock and reset stay outside.
//
//   SPI pins     : sclk_i, cs_ni, mosi_i (raw, asynchronous), miso_o, miso_oe_o
//   TX side      : tx_data_i, tx_valid_i, tx_ready_o (valid/ready write)
//   RX side      : rx_data_o, rx_valid_o (one-cycle pulse)
//   Status       : underrun_o, frame_err_o (one-cycle pulses), busy_o
//
// Modport slave is the controller's view; modport master is the
// environment's view (SPI master plus the local TX/RX client).
interface spi_slave_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              sclk_i;
    logic              cs_ni;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              underrun_o;
    logic              frame_err_o;
    logic              busy_o;

    modport slave (
        input  sclk_i, cs_ni, mosi_i, tx_data_i, tx_valid_i,
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               underrun_o, frame_err_o, busy_o
    );

    modport master (
        output sclk_i, cs_ni, mosi_i, tx_data_i, tx_valid_i,
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               underrun_o, frame_err_o, busy_o
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave controller, oversampled by the system clock.
//
// The raw SPI pins are brought into the clk_i domain through 3-flop
// synchronizers; every decision is taken on edge events of the synchronized
// values, so SCLK must be at most clk_i/8. Words are DATA_W bits, MSB first
// in both directions. A single-entry holding register feeds the TX shifter
// at CS assertion and at each word boundary; an empty register sends zeros
// and flags an underrun.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     spi_slave_ctrl_if.slave: SPI pins, TX write (tx_data_i,
//           tx_valid_i, tx_ready_o), RX word (rx_data_o, rx_valid_o),
//           underrun_o / frame_err_o pulses, busy_o (high in SHIFT)
module spi_slave_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    spi_slave_ctrl_if.slave      bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronizer stages _p0.._p2; _p3 is the previous synchronized value
    // used only for edge detection.
    logic sclk_p0, sclk_p1, sclk_p2, sclk_p3;
    logic cs_p0, cs_p1, cs_p2, cs_p3;
    logic mosi_p0, mosi_p1, mosi_p2;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-2:0] rx_sh;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              rx_valid_q;
    logic              underrun_q;
    logic              frame_err_q;
    logic              busy_q;

    logic              sclk_rise, sclk_fall;
    logic              cs_assert, cs_deassert, cs_active;
    logic              load_req;
    logic [DATA_W-1:0] rx_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            sclk_p3 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            cs_p3   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            mosi_p2 <= 1'b0;
        end else begin
            sclk_p0 <= bus.sclk_i;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            sclk_p3 <= sclk_p2;
            cs_p0   <= bus.cs_ni;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            cs_p3   <= cs_p2;
            mosi_p0 <= bus.mosi_i;
            mosi_p1 <= mosi_p0;
            mosi_p2 <= mosi_p1;
        end
    end

    // Synchronized edge events, valid for exactly one clk_i cycle
    assign sclk_rise   = ~sclk_p3 &  sclk_p2;
    assign sclk_fall   =  sclk_p3 & ~sclk_p2;
    assign cs_assert   =  cs_p3   & ~cs_p2;
    assign cs_deassert = ~cs_p3   &  cs_p2;
    assign cs_active   = ~cs_p2;

    assign rx_next = {rx_sh, mosi_p2};

    // TX shifter reload points: frame start, and the SCLK falling edge that
    // follows the last bit of a word (counter already wrapped to 0).
    always_comb begin
        load_req = 1'b0;
        case (state)
            IDLE:    load_req = cs_assert;
            SHIFT:   load_req = ~cs_deassert & sclk_fall & (bit_cnt == '0);
            default: load_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_data_q   <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // A write and a load never both touch hold_full: writes need it
            // clear, consuming loads need it set. A load that finds it clear
            // sends zeros even if a write lands in the same cycle.
            if (bus.tx_valid_i && !hold_full) begin
                hold      <= bus.tx_data_i;
                hold_full <= 1'b1;
            end

            if (load_req) begin
                if (hold_full) begin
                    tx_sh     <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_sh      <= '0;
                    underrun_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cs_assert) begin
                        state   <= SHIFT;
                        busy_q  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_deassert) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        rx_sh <= rx_next[DATA_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso_o      = cs_active & tx_sh[DATA_W-1];
    assign bus.miso_oe_o   = cs_active;
    assign bus.tx_ready_o  = ~hold_full;
    assign bus.rx_data_o   = rx_data_q;
    assign bus.rx_valid_o  = rx_valid_q;
    assign bus.underrun_o  = underrun_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl (DATA_W = 8).
// A word-level reference model (bit queues, word/index bookkeeping) runs
// alongside the DUT; one process compares every output each cycle, and the
// directed scenarios add hand-computed literal expectations.
module tb_spi_slave_ctrl;

    localparam int DATA_W = 8;
    localparam int HALF   = 5;   // SCLK half period in clk_i cycles

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    spi_slave_ctrl_if #(.DATA_W(DATA_W)) bus();

    spi_slave_ctrl #(.DATA_W(DATA_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [3:0]        m_sclk, m_cs;   // [2] = synchronized value, [3] = previous
    logic [2:0]        m_mosi;
    bit                m_in_frame;
    int                m_nrise;
    bit                m_q[$];
    logic [DATA_W-1:0] m_rx_data, m_tx_word, m_hold;
    int                m_tx_idx;
    bit                m_full;
    bit                e_rx_valid, e_underrun, e_ferr;

    task automatic model_reset();
        m_sclk = '0; m_cs = '1; m_mosi = '0;
        m_in_frame = 0; m_nrise = 0; m_q.delete();
        m_rx_data = '0; m_tx_word = '0; m_hold = '0; m_tx_idx = 0; m_full = 0;
        e_rx_valid = 0; e_underrun = 0; e_ferr = 0;
    endtask

    task automatic model_load();
        if (m_full) begin
            m_tx_word = m_hold;
            m_full = 0;
        end else begin
            m_tx_word = '0;
            e_underrun = 1;
        end
        m_tx_idx = 0;
    endtask

    task automatic model_step();
        bit s_rise, s_fall, c_as, c_de, full_before;
        logic [DATA_W-1:0] w;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        s_rise = !m_sclk[3] && m_sclk[2];
        s_fall = m_sclk[3] && !m_sclk[2];
        c_as   = m_cs[3] && !m_cs[2];
        c_de   = !m_cs[3] && m_cs[2];
        full_before = m_full;
        e_rx_valid = 0; e_underrun = 0; e_ferr = 0;
        if (!m_in_frame) begin
            if (c_as) begin
                m_in_frame = 1;
                m_nrise = 0;
                m_q.delete();
                model_load();
            end
        end else if (c_de) begin
            m_in_frame = 0;
            if (m_nrise != 0) e_ferr = 1;
        end else if (s_rise) begin
            m_q.push_back(m_mosi[2]);
            m_nrise++;
            if (m_nrise == DATA_W) begin
                for (int i = 0; i < DATA_W; i++) w[DATA_W-1-i] = m_q[i];
                m_rx_data = w;
                e_rx_valid = 1;
                m_nrise = 0;
                m_q.delete();
            end
        end else if (s_fall) begin
            if (m_nrise == 0) model_load();
            else m_tx_idx++;
        end
        if (bus.tx_valid_i && !full_before) begin
            m_hold = bus.tx_data_i;
            m_full = 1;
        end
        m_sclk = {m_sclk[2:0], bus.sclk_i};
        m_cs   = {m_cs[2:0], bus.cs_ni};
        m_mosi = {m_mosi[1:0], bus.mosi_i};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic em, eoe;
        forever begin
            @(negedge clk_i);
            if (cmp_en) begin
                eoe = !m_cs[2];
                em  = (eoe && m_tx_idx < DATA_W) ? m_tx_word[DATA_W-1-m_tx_idx] : 1'b0;
                chk("miso_o",      32'(bus.miso_o),      32'(em));
                chk("miso_oe_o",   32'(bus.miso_oe_o),   32'(eoe));
                chk("tx_ready_o",  32'(bus.tx_ready_o),  32'(!m_full));
                chk("rx_data_o",   32'(bus.rx_data_o),   32'(m_rx_data));
                chk("rx_valid_o",  32'(bus.rx_valid_o),  32'(e_rx_valid));
                chk("underrun_o",  32'(bus.underrun_o),  32'(e_underrun));
                chk("frame_err_o", 32'(bus.frame_err_o), 32'(e_ferr));
                chk("busy_o",      32'(bus.busy_o),      32'(m_in_frame));
            end
        end
    end

    // Pulse counters for the literal checks
    int c_rxv = 0, c_und = 0, c_fer = 0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (bus.rx_valid_o === 1'b1)  c_rxv++;
            if (bus.underrun_o === 1'b1)  c_und++;
            if (bus.frame_err_o === 1'b1) c_fer++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tx_write(input logic [DATA_W-1:0] d);
        @(negedge clk_i);
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        @(negedge clk_i);
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic cs_low();
        bus.cs_ni = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk_i);
        bus.cs_ni = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        bus.mosi_i = b;
        repeat (HALF) @(negedge clk_i);
        m = bus.miso_o;
        bus.sclk_i = 1'b1;
        repeat (HALF) @(negedge clk_i);
        bus.sclk_i = 1'b0;
    endtask

    task automatic spi_word(input logic [DATA_W-1:0] w, output logic [DATA_W-1:0] mw);
        logic m;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            spi_bit(w[i], m);
            mw[i] = m;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"},     32'(bus.miso_o),      32'd0);
        chk({tag, "_oe"},       32'(bus.miso_oe_o),   32'd0);
        chk({tag, "_tx_ready"}, 32'(bus.tx_ready_o),  32'd1);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid_o),  32'd0);
        chk({tag, "_underrun"}, 32'(bus.underrun_o),  32'd0);
        chk({tag, "_frame_err"},32'(bus.frame_err_o), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy_o),      32'd0);
        chk({tag, "_rx_data"},  32'(bus.rx_data_o),   32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [DATA_W-1:0] mw, mw2;
        int b_rxv, b_und, b_fer;
        logic m;

        bus.sclk_i = 1'b0; bus.cs_ni = 1'b1; bus.mosi_i = 1'b0;
        bus.tx_data_i = '0; bus.tx_valid_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        cmp_en = 1'b1;

        // Basic transfer: TX 0xA5, RX 0x3C; the end-of-word reload finds the
        // register empty and flags one underrun.
        b_rxv = c_rxv; b_und = c_und;
        tx_write(8'hA5);
        cs_low();
        spi_word(8'h3C, mw);
        cs_high();
        chk("t1_miso_word", 32'(mw), 32'hA5);
        chk("t1_rx_data",   32'(bus.rx_data_o), 32'h3C);
        chk("t1_rx_pulses", 32'(c_rxv - b_rxv), 32'd1);
        chk("t1_underruns", 32'(c_und - b_und), 32'd1);

        // No TX write: underrun at CS assert and again at the word boundary.
        b_rxv = c_rxv; b_und = c_und;
        cs_low();
        chk("t2_underrun_at_cs", 32'(c_und - b_und), 32'd1);
        spi_word(8'hE7, mw);
        cs_high();
        chk("t2_miso_word", 32'(mw), 32'h00);
        chk("t2_rx_data",   32'(bus.rx_data_o), 32'hE7);
        chk("t2_rx_pulses", 32'(c_rxv - b_rxv), 32'd1);
        chk("t2_underruns", 32'(c_und - b_und), 32'd2);

        // Two words in one frame, second TX word written during the first.
        b_rxv = c_rxv; b_und = c_und;
        tx_write(8'h11);
        cs_low();
        tx_write(8'h22);
        spi_word(8'h5A, mw);
        chk("t3_rx_word0", 32'(bus.rx_data_o), 32'h5A);
        spi_word(8'hC3, mw2);
        cs_high();
        chk("t3_miso_word0", 32'(mw),  32'h11);
        chk("t3_miso_word1", 32'(mw2), 32'h22);
        chk("t3_rx_data",    32'(bus.rx_data_o), 32'hC3);
        chk("t3_rx_pulses",  32'(c_rxv - b_rxv), 32'd2);
        chk("t3_underruns",  32'(c_und - b_und), 32'd1);

        // Short frame: 5 bits then CS deassert.
        b_rxv = c_rxv; b_fer = c_fer;
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'(i & 1), m);
        cs_high();
        chk("t4_frame_err", 32'(c_fer - b_fer), 32'd1);
        chk("t4_rx_pulses", 32'(c_rxv - b_rxv), 32'd0);
        chk("t4_rx_data",   32'(bus.rx_data_o), 32'hC3);
        chk("t4_busy",      32'(bus.busy_o), 32'd0);

        // Reset after 3 bits, then a normal frame.
        b_fer = c_fer; b_rxv = c_rxv;
        tx_write(8'h0F);
        cs_low();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("midrst");
        bus.cs_ni = 1'b1; bus.mosi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("t5_no_pulses", 32'((c_fer - b_fer) + (c_rxv - b_rxv)), 32'd0);
        b_rxv = c_rxv;
        tx_write(8'h96);
        cs_low();
        spi_word(8'h69, mw);
        cs_high();
        chk("t5_miso_word", 32'(mw), 32'h96);
        chk("t5_rx_data",   32'(bus.rx_data_o), 32'h69);
        chk("t5_rx_pulses", 32'(c_rxv - b_rxv), 32'd1);

        // SCLK activity with CS high is ignored.
        b_rxv = c_rxv;
        for (int i = 0; i < 10; i++) spi_bit(1'(i & 1), m);
        repeat (8) @(negedge clk_i);
        chk("t6_rx_pulses", 32'(c_rxv - b_rxv), 32'd0);
        chk("t6_busy",      32'(bus.busy_o), 32'd0);
        chk("t6_oe",        32'(bus.miso_oe_o), 32'd0);
        chk("t6_rx_data",   32'(bus.rx_data_o), 32'h69);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
